alu_result_stage: RTL and testbench

Registered output stage for the 16-bit ALU. Captures the word assembled from the per-bit result muxes (AND/OR/XOR/adder select) together with carry/overflow from the MSB adder slice. Derives the NZCV flags and presents result, destination address and flags to register-file writeback over a valid/ready handshake. Also maintains the architectural flag register read by the branch logic.

---
 rtl/alu_result_stage_if.sv | 35 +++
 rtl/alu_result_stage.sv | 111 +++++++++++
 tb/tb_alu_result_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Bundle between the ALU result muxes, the output stage and register-file writeback.
// Latency: none, this is wiring only.
// Backpressure: carries in_ready/out_ready; the stage side uses the slave modport.
// Ports: in_valid/in_ready with Rezultati, CarryOut, Overflow, S, RdAdr on the ALU side;
//        out_valid/out_ready with WrData, WrAdr, WrFlags on the writeback side; Flamujt to branch logic.
interface alu_result_stage_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  Rezultati;
    logic              CarryOut;
    logic              Overflow;
    logic [2:0]        S;
    logic [ADDR_W-1:0] RdAdr;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  WrData;
    logic [ADDR_W-1:0] WrAdr;
    logic [3:0]        WrFlags;
    logic [3:0]        Flamujt;

    // Driver side: ALU plus writeback consumer (the bench plays both roles).
    modport master (
        output in_valid, Rezultati, CarryOut, Overflow, S, RdAdr, out_ready,
        input  in_ready, out_valid, WrData, WrAdr, WrFlags, Flamujt
    );

    // The result stage itself.
    modport slave (
        input  in_valid, Rezultati, CarryOut, Overflow, S, RdAdr, out_ready,
        output in_ready, out_valid, WrData, WrAdr, WrFlags, Flamujt
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: captures result word + NZCV, hands it to writeback, keeps the flag register.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: default build has a single register, in_ready = !out_valid || out_ready;
//               with ALU_STAGE_SKID_EN a two-entry skid buffer makes in_ready a flop output (!skid_full).
// Ports: Clock, Reset (synchronous, active high); bus (alu_result_stage_if.slave) carries both
//        handshakes, the result/flag/address fields and the architectural flag register Flamujt.
module alu_result_stage #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    alu_result_stage_if.slave   bus
);
    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [ADDR_W-1:0] adr;
        logic [3:0]        flags;   // {N,Z,C,V}
    } entry_t;

    entry_t in_ent;
    entry_t main_q;
    logic   main_vld;
    logic   in_xfer;
    logic   out_xfer;
    logic   arith;
    logic   sel_unused;
    logic [3:0] flam_q;

    // Only the arithmetic/logic split matters for flags; the logic sub-op has no flag effect.
    assign arith      = bus.S[2];
    assign sel_unused = ^bus.S[1:0];

    // Logic ops force C/V to 0 so a retiring logic op clears them in the flag register.
    always_comb begin
        in_ent       = '0;
        in_ent.data  = bus.Rezultati;
        in_ent.adr   = bus.RdAdr;
        in_ent.flags = {bus.Rezultati[WIDTH-1],
                        (bus.Rezultati == '0),
                        arith & bus.CarryOut,
                        arith & bus.Overflow};
    end

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = main_vld && bus.out_ready;

`ifdef ALU_STAGE_SKID_EN
    entry_t skid_q;
    logic   skid_vld;

    // in_ready comes straight from the skid-occupancy flop; Reset only masks it.
    assign bus.in_ready = !skid_vld && !Reset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            main_q   <= '0;
            main_vld <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_xfer) begin
            // Main slot is free this edge: skid has priority to keep FIFO order.
            // in_xfer cannot coincide with a full skid since in_ready is low then.
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                if (in_xfer) begin
                    main_q <= in_ent;
                end
                main_vld <= in_xfer;
            end
        end else if (in_xfer) begin
            // Main is stalled: park the new word.
            skid_q   <= in_ent;
            skid_vld <= 1'b1;
        end
    end
`else
    assign bus.in_ready = !Reset && (!main_vld || bus.out_ready);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            main_q   <= '0;
            main_vld <= 1'b0;
        end else if (in_xfer) begin
            // Covers both empty-load and same-edge replace; out_valid stays high.
            main_q   <= in_ent;
            main_vld <= 1'b1;
        end else if (out_xfer) begin
            main_vld <= 1'b0;
        end
    end
`endif

    // Architectural flags follow the word that actually retires to writeback.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            flam_q <= '0;
        end else if (out_xfer) begin
            flam_q <= main_q.flags;
        end
    end

    assign bus.out_valid = main_vld;
    assign bus.WrData    = main_q.data;
    assign bus.WrAdr     = main_q.adr;
    assign bus.WrFlags   = main_q.flags;
    assign bus.Flamujt   = flam_q;
endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  a;
        logic [3:0]  f;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    alu_result_stage_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [3:0] exp_flam = 4'b0;
    logic last_acc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [2:0] s, input logic [15:0] r,
                                            input logic c, input logic v);
        logic [3:0] f;
        f[3] = r[15];
        f[2] = (r == 16'h0);
        f[1] = s[2] ? c : 1'b0;
        f[0] = s[2] ? v : 1'b0;
        return f;
    endfunction

    task automatic drive(input logic vld, input logic [2:0] s, input logic [15:0] r,
                         input logic c, input logic v, input logic [2:0] a, input logic ordy);
        bus.in_valid  = vld;
        bus.S         = s;
        bus.Rezultati = r;
        bus.CarryOut  = c;
        bus.Overflow  = v;
        bus.RdAdr     = a;
        bus.out_ready = ordy;
    endtask

    // One clock: sample just after inputs settle, score transfers, advance to next negedge.
    task automatic step();
        logic       upd;
        logic [3:0] nf;
        logic       exp_rdy;
        exp_t       e;
        upd = 1'b0;
        nf  = 4'b0;
        last_acc = 1'b0;
        #1;
        if (Reset) begin
            chk("in_ready_in_reset", bus.in_ready, 0);
        end else begin
            chk("out_valid", bus.out_valid, (sb.size() != 0));
`ifdef ALU_STAGE_SKID_EN
            exp_rdy = (sb.size() < 2);
`else
            exp_rdy = (sb.size() == 0) || bus.out_ready;
`endif
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("flamujt", bus.Flamujt, exp_flam);
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("wrdata", bus.WrData, e.d);
                chk("wradr", bus.WrAdr, e.a);
                chk("wrflags", bus.WrFlags, e.f);
                upd = 1'b1;
                nf  = e.f;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back({bus.Rezultati, bus.RdAdr,
                              flags_of(bus.S, bus.Rezultati, bus.CarryOut, bus.Overflow)});
                last_acc = 1'b1;
            end
        end
        @(posedge Clock);
        if (Reset) begin
            sb.delete();
            exp_flam = 4'b0;
        end else if (upd) begin
            exp_flam = nf;
        end
        @(negedge Clock);
    endtask

    task automatic drain(input string tag);
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        chk(tag, sb.size(), 0);
        step();
    endtask

    initial begin
        logic [15:0] w;
        int          stall_words;
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_wrdata", bus.WrData, 0);
        chk("rst_wradr", bus.WrAdr, 0);
        chk("rst_wrflags", bus.WrFlags, 0);
        chk("rst_flamujt", bus.Flamujt, 0);
        #1 chk("rdy_after_rst", bus.in_ready, 1);
        @(negedge Clock);

        // Arithmetic zero with carry.
        drive(1'b1, 3'b100, 16'h0000, 1'b1, 1'b0, 3'd5, 1'b0);
        step();
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.WrData, 16'h0000);
        chk("t1_adr", bus.WrAdr, 5);
        chk("t1_flags", bus.WrFlags, 4'b0110);
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("t1_flamujt", bus.Flamujt, 4'b0110);

        // XOR drops carry/overflow.
        drive(1'b1, 3'b011, 16'h8001, 1'b1, 1'b1, 3'd2, 1'b0);
        step();
        chk("xor_flags", bus.WrFlags, 4'b1000);
        drain("xor_drain");
        chk("xor_flamujt", bus.Flamujt, 4'b1000);

        // Back-to-back at full rate.
        drive(1'b1, 3'b010, 16'h1111, 1'b0, 1'b0, 3'd1, 1'b1);
        step();
        chk("b2b_a", bus.WrData, 16'h1111);
        drive(1'b1, 3'b010, 16'h2222, 1'b0, 1'b0, 3'd2, 1'b1);
        step();
        chk("b2b_b_valid", bus.out_valid, 1);
        chk("b2b_b", bus.WrData, 16'h2222);
        drive(1'b1, 3'b010, 16'h3333, 1'b0, 1'b0, 3'd3, 1'b1);
        step();
        chk("b2b_c_valid", bus.out_valid, 1);
        chk("b2b_c", bus.WrData, 16'h3333);
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("b2b_end_valid", bus.out_valid, 0);

        // Stall for 4 cycles with input pressure.
        w = 16'hA001;
        stall_words = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b001, w, 1'b0, 1'b0, w[2:0], 1'b0);
            step();
            if (last_acc) begin
                w = w + 16'h1;
                stall_words++;
            end
            chk("stall_hold", bus.WrData, 16'hA001);
        end
`ifdef ALU_STAGE_SKID_EN
        chk("stall_accepted", stall_words, 2);
`else
        chk("stall_accepted", stall_words, 1);
`endif
        drain("stall_drain");

        // Flag register 1010, then reset with words buffered.
        drive(1'b1, 3'b110, 16'h8000, 1'b1, 1'b0, 3'd7, 1'b1);
        step();
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("pre_rst_flamujt", bus.Flamujt, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b101, 16'h5A00 + 16'(i), 1'b1, 1'b1, 3'(i), 1'b0);
            step();
        end
        Reset = 1'b1;
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        Reset = 1'b0;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_flamujt", bus.Flamujt, 0);
        chk("mid_rst_wrdata", bus.WrData, 0);
        for (int i = 0; i < 3; i++) step();

        // Flag register holds through a stall.
        drive(1'b1, 3'b000, 16'h0000, 1'b1, 1'b1, 3'd4, 1'b1);
        step();
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("fl_base", bus.Flamujt, 4'b0100);
        drive(1'b1, 3'b111, 16'h8000, 1'b1, 1'b0, 3'd6, 1'b0);
        step();
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_stall", bus.Flamujt, 4'b0100);
        end
        drive(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("fl_retire", bus.Flamujt, 4'b1010);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 3'($urandom),
                  ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 15) == 0) bus.Rezultati = 16'h0;
            step();
        end
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
